// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter for the seven-segment digits.
// One bit per cycle; formatted digits (blanking/overflow as 4'hF) are latched on done.
module bin_to_bcd_seq #(
  parameter int BIN_W    = 10,
  parameter int N_DIGITS = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*N_DIGITS-1:0] bcd_out
);

  localparam int SW = 4*N_DIGITS + 4;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [BIN_W-1:0]      sh_q, sh_nx;
  logic [SW-1:0]         scr_q, scr_adj, scr_nx;
  logic                  carry_q, carry_nx;
  logic [4*N_DIGITS-1:0] bcd_q;
  logic                  ovf_q, ovf_res;
  logic                  load, last, fin;

  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < N_DIGITS + 1; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Overflow forces every digit dark; otherwise optionally darken leading zeros.
  function automatic logic [4*N_DIGITS-1:0] fmt(input logic [SW-1:0] s, input logic ovf);
    logic [4*N_DIGITS-1:0] r;
    logic                  lead;
    r    = s[4*N_DIGITS-1:0];
    lead = 1'b1;
    if (ovf) begin
      r = '1;
    end else if (BLANK_LZ != 0) begin
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
        if (lead && (r[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
    return r;
  endfunction

  assign scr_adj  = add3(scr_q);
  assign scr_nx   = {scr_adj[SW-2:0], sh_q[BIN_W-1]};
  assign sh_nx    = sh_q << 1;
  assign carry_nx = carry_q | scr_adj[SW-1];
  assign ovf_res  = carry_nx | (scr_nx[SW-1 -: 4] != 4'd0);
  assign last     = (cnt_q == CW'(BIN_W - 1));
  assign fin      = (state_q == SHIFT) && last;
  assign load     = start && (state_q != SHIFT);

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= fmt('0, 1'b0);
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load)                    cnt_q <= '0;
      else if (state_q == SHIFT)   cnt_q <= cnt_q + CW'(1);
      if (fin) begin
        bcd_q <= fmt(scr_nx, ovf_res);
        ovf_q <= ovf_res;
      end
    end
  end

  // Shift datapath carries no reset: it is always reloaded before use.
  always_ff @(posedge clock) begin
    if (load) begin
      sh_q    <= bin_in;
      scr_q   <= '0;
      carry_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      sh_q    <= sh_nx;
      scr_q   <= scr_nx;
      carry_q <= carry_nx;
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: default 4-digit blanking instance plus a
// 3-digit unblanked instance for overflow behaviour.
module tb_bin_to_bcd_seq;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start, start2;
  logic [9:0]  bin_in, bin2;
  logic        busy, done, overflow;
  logic        busy2, done2, overflow2;
  logic [15:0] bcd_out;
  logic [11:0] bcd2;

  int checks = 0;
  int errs   = 0;

  always #5 clock = ~clock;

  bin_to_bcd_seq dut (
    .clock(clock), .resetn(resetn), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .overflow(overflow), .bcd_out(bcd_out)
  );

  bin_to_bcd_seq #(.BIN_W(10), .N_DIGITS(3), .BLANK_LZ(0)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .overflow(overflow2), .bcd_out(bcd2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called just after the accepting edge; returns edges until done and busy cycles seen.
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      tick();
      n++;
    end
  endtask

  task automatic conv(input logic [9:0] v, input logic [15:0] exp, input string tag);
    int n, nb;
    start  = 1'b1;
    bin_in = v;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    check({tag, "_lat"}, n, 10);
    check({tag, "_busy"}, nb, 10);
    check({tag, "_bcd"}, bcd_out, exp);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_busy_in_done"}, busy, 0);
    tick();
    check({tag, "_done_w"}, done, 0);
  endtask

  task automatic conv2(input logic [9:0] v, input logic [11:0] exp, input logic ovf, input string tag);
    int n;
    start2 = 1'b1;
    bin2   = v;
    tick();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 10);
    check({tag, "_bcd"}, bcd2, exp);
    check({tag, "_ovf"}, overflow2, ovf);
  endtask

  initial begin
    int n, nb, nd;
    resetn = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    bin_in = '0;
    bin2   = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_bcd", bcd_out, 16'hFFF0);
    check("rst_bcd2", bcd2, 12'h000);
    resetn = 1'b1;
    tick();

    conv(10'd0, 16'hFFF0, "zero");
    conv(10'd123, 16'hF123, "v123");

    // back-to-back: restart in the DONE cycle
    start  = 1'b1;
    bin_in = 10'd1023;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    check("b2b_first_lat", n, 10);
    check("b2b_first_bcd", bcd_out, 16'h1023);
    start  = 1'b1;
    bin_in = 10'd7;
    tick();
    start = 1'b0;
    check("b2b_no_gap_busy", busy, 1);
    check("b2b_done_drop", done, 0);
    check("b2b_bcd_held", bcd_out, 16'h1023);
    wait_done(n, nb);
    check("b2b_second_lat", n, 10);
    check("b2b_second_bcd", bcd_out, 16'hFFF7);

    // start while busy is ignored
    tick();
    start  = 1'b1;
    bin_in = 10'd456;
    tick();
    start = 1'b0;
    tick();
    tick();
    start  = 1'b1;
    bin_in = 10'd999;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    check("ign_lat", n, 7);
    check("ign_bcd", bcd_out, 16'hF456);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) nd++;
    end
    check("ign_no_second_done", nd, 0);
    check("ign_bcd_held", bcd_out, 16'hF456);

    // reset mid-conversion
    start  = 1'b1;
    bin_in = 10'd800;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bcd", bcd_out, 16'hFFF0);
    check("abort_ovf", overflow, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    resetn = 1'b1;
    tick();
    conv(10'd42, 16'hFF42, "v42");

    // 3-digit unblanked instance
    conv2(10'd999, 12'h999, 1'b0, "d3_999");
    tick();
    conv2(10'd1000, 12'hFFF, 1'b1, "d3_1000");
    tick();
    conv2(10'd5, 12'h005, 1'b0, "d3_5");

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
